// File: rtl/laser_frame_receiver_if.sv
// Bundle of enable, line input and received-byte signals between the laser receiver and its user.
// The receiver uses the slave modport; the FTDI write path or a bench uses the master modport.
interface laser_frame_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 en;
    logic                 laser_rx;
    logic                 data_valid;
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_error;
    logic                 busy;
    logic [15:0]          frame_count;
    logic [7:0]           error_count;

    modport master (
        output en, laser_rx,
        input  data_valid, data_out, frame_error, busy, frame_count, error_count
    );

    modport slave (
        input  en, laser_rx,
        output data_valid, data_out, frame_error, busy, frame_count, error_count
    );
endinterface

// File: rtl/laser_frame_receiver.sv
// Laser link deserializer: synchronizes the photodiode level, majority-votes each bit at mid-bit,
// checks the stop bit and delivers good bytes as a one-cycle strobe with frame/error counters.
module laser_frame_receiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    laser_frame_receiver_if.slave bus
);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_SA   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_SB   = CW'(MID);
    localparam logic [CW-1:0] CNT_VOTE = CW'(MID + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;
    logic [CW-1:0]        clk_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 samp_a;
    logic                 samp_b;
    logic                 vote;
    logic                 at_vote;
    logic                 shift_en;
    logic                 accept_byte;
    logic                 flag_error;
    logic                 busy_c;
    logic                 data_valid_r;
    logic                 frame_error_r;
    logic [DATA_BITS-1:0] data_out_r;
    logic [15:0]          frame_count_r;
    logic [7:0]           error_count_r;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
            rx_d    <= 1'b0;
        end else begin
            rx_meta <= bus.laser_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // The MID+1 sample is taken live so the registered decision lands one edge later.
    assign at_vote = (clk_cnt == CNT_VOTE);
    assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rx_s && !rx_d) state_next = START;
            START:   if (at_vote) state_next = vote ? DATA : IDLE;
            DATA:    if (at_vote && bit_cnt == BIT_LAST) state_next = STOP;
            STOP:    if (at_vote) state_next = vote ? BREAK : IDLE;
            BREAK:   if (!rx_s && clk_cnt == CNT_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!bus.en) state_next = IDLE;
    end

    always_comb begin
        shift_en    = 1'b0;
        accept_byte = 1'b0;
        flag_error  = 1'b0;
        busy_c      = (state != IDLE);
        if (bus.en && at_vote) begin
            case (state)
                DATA:    shift_en = 1'b1;
                STOP:    begin
                    accept_byte = !vote;
                    flag_error  = vote;
                end
                default: ;
            endcase
        end
    end

    // In BREAK clk_cnt counts consecutive dark clocks instead of bit phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_cnt <= '0;
        end else if (state == IDLE || state_next == IDLE ||
                     (state == STOP && state_next == BREAK) ||
                     (state == BREAK && rx_s)) begin
            clk_cnt <= '0;
        end else if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            samp_a    <= 1'b0;
            samp_b    <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (clk_cnt == CNT_SA) samp_a <= rx_s;
            if (clk_cnt == CNT_SB) samp_b <= rx_s;
            if (state == START)  bit_cnt <= '0;
            else if (shift_en)   bit_cnt <= bit_cnt + 1'b1;
            if (shift_en) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            data_out_r    <= '0;
            frame_count_r <= '0;
            error_count_r <= '0;
        end else begin
            data_valid_r  <= accept_byte;
            frame_error_r <= flag_error;
            if (accept_byte) begin
                data_out_r    <= shift_reg;
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (flag_error && error_count_r != 8'hFF) error_count_r <= error_count_r + 8'd1;
        end
    end

    // Strobes are masked so nothing is announced while the receiver is disabled.
    assign bus.data_valid  = data_valid_r & bus.en;
    assign bus.frame_error = frame_error_r & bus.en;
    assign bus.data_out    = data_out_r;
    assign bus.busy        = busy_c;
    assign bus.frame_count = frame_count_r;
    assign bus.error_count = error_count_r;
endmodule
